// File: rtl/uart_alu_loader.sv
// UART receiver (8N1, or 8E1 with UART_ALU_LOADER_PARITY_EN) that feeds an ALU with operand A, operand B, then opcode.
// Enable pulse and o_data appear one cycle after the stop-bit sample; there is no backpressure, so bytes are pushed as they arrive.
module uart_alu_loader #(
  parameter int NB_DATA   = 8,
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 19200
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_rx,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_enable_1,
  output logic               o_enable_2,
  output logic               o_enable_3,
  output logic               o_busy,
  output logic               o_frame_error
);

  localparam int DIV   = CLK_FREQ / (BAUD_RATE * 16);
  localparam int DIV_W = $clog2(DIV + 1);
  localparam int BIT_W = $clog2(NB_DATA + 1);

`ifdef UART_ALU_LOADER_PARITY_EN
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
`else
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
`endif
  typedef enum logic [1:0] {LD_WAIT_A, LD_WAIT_B, LD_WAIT_OP} ld_state_t;

  rx_state_t          rx_state, rx_next;
  ld_state_t          ld_state, ld_next;
  logic               rx_meta, rx_sync;
  logic [DIV_W-1:0]   baud_cnt;
  logic [3:0]         s_cnt;
  logic [BIT_W-1:0]   bit_cnt;
  logic [NB_DATA-1:0] shreg;
  logic               line_hold;
  logic               tick, mid_tick, end_tick, last_bit;
  logic               start_det, byte_done, frame_err, stop_ok;

  assign tick     = (baud_cnt == DIV_W'(DIV - 1));
  assign mid_tick = tick && (s_cnt == 4'd7);
  assign end_tick = tick && (s_cnt == 4'd15);
  assign last_bit = (bit_cnt == BIT_W'(NB_DATA - 1));
  assign o_busy   = (rx_state != RX_IDLE);

`ifdef UART_ALU_LOADER_PARITY_EN
  logic par_err;
  assign stop_ok = rx_sync && !par_err;
`else
  assign stop_ok = rx_sync;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_sync <= rx_meta;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rx_state <= RX_IDLE;
      ld_state <= LD_WAIT_A;
    end else begin
      rx_state <= rx_next;
      ld_state <= ld_next;
    end
  end

  always_comb begin
    rx_next   = rx_state;
    start_det = 1'b0;
    byte_done = 1'b0;
    frame_err = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        // After a frame error the line must go high again before a new start is accepted (break handling)
        if (!rx_sync && !line_hold) begin
          rx_next   = RX_START;
          start_det = 1'b1;
        end
      end
      RX_START: if (mid_tick) rx_next = rx_sync ? RX_IDLE : RX_DATA;
`ifdef UART_ALU_LOADER_PARITY_EN
      RX_DATA:   if (end_tick && last_bit) rx_next = RX_PARITY;
      RX_PARITY: if (end_tick) rx_next = RX_STOP;
`else
      RX_DATA:   if (end_tick && last_bit) rx_next = RX_STOP;
`endif
      RX_STOP: begin
        if (end_tick) begin
          rx_next   = RX_IDLE;
          byte_done = stop_ok;
          frame_err = !stop_ok;
        end
      end
      default: rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      baud_cnt  <= '0;
      s_cnt     <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      line_hold <= 1'b0;
    end else begin
      // Restarting the divider on start detect keeps every sample point phase-locked to the falling edge
      baud_cnt <= (start_det || tick) ? '0 : baud_cnt + 1'b1;
      if (start_det || (rx_state == RX_START && mid_tick)) s_cnt <= '0;
      else if (tick) s_cnt <= s_cnt + 1'b1;
      if (rx_state == RX_DATA && end_tick) begin
        shreg   <= {rx_sync, shreg[NB_DATA-1:1]};
        bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
      end
      if (frame_err) line_hold <= 1'b1;
      else if (rx_sync) line_hold <= 1'b0;
    end
  end

`ifdef UART_ALU_LOADER_PARITY_EN
  always_ff @(posedge i_clk) begin
    if (i_reset || start_det) par_err <= 1'b0;
    else if (rx_state == RX_PARITY && end_tick) par_err <= rx_sync ^ (^shreg);
  end
`endif

  always_comb begin
    ld_next = ld_state;
    if (frame_err) ld_next = LD_WAIT_A;
    else if (byte_done) begin
      case (ld_state)
        LD_WAIT_A: ld_next = LD_WAIT_B;
        LD_WAIT_B: ld_next = LD_WAIT_OP;
        default:   ld_next = LD_WAIT_A;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_data        <= '0;
      o_enable_1    <= 1'b0;
      o_enable_2    <= 1'b0;
      o_enable_3    <= 1'b0;
      o_frame_error <= 1'b0;
    end else begin
      o_enable_1 <= byte_done && (ld_state == LD_WAIT_A);
      o_enable_2 <= byte_done && (ld_state == LD_WAIT_B);
      o_enable_3 <= byte_done && (ld_state == LD_WAIT_OP);
      if (byte_done) begin
        o_data        <= shreg;
        o_frame_error <= 1'b0;
      end else if (frame_err) begin
        o_frame_error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_alu_loader.sv
// Directed bench for uart_alu_loader with a small divider (DIV = floor(1700000/400000) = 4, 64 clocks per bit).
module tb_uart_alu_loader;

  localparam int CLK_FREQ = 1_700_000;
  localparam int BAUD     = 25_000;
  localparam int BIT_CYC  = 64;
`ifdef UART_ALU_LOADER_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  // 2 sync flops + 1 detect cycle, then 8 ticks to mid-start and 16 per following bit, 4 clocks per tick
  localparam int STOP_LAT = 3 + 4 * (8 + 16 * (NBITS - 1));

  logic       clk = 1'b0;
  logic       reset, rx;
  logic [7:0] o_data;
  logic       o_enable_1, o_enable_2, o_enable_3, o_busy, o_frame_error;

  uart_alu_loader #(.NB_DATA(8), .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD)) dut (
    .i_clk(clk), .i_reset(reset), .i_rx(rx), .o_data(o_data),
    .o_enable_1(o_enable_1), .o_enable_2(o_enable_2), .o_enable_3(o_enable_3),
    .o_busy(o_busy), .o_frame_error(o_frame_error)
  );

  always #10 clk = ~clk;

  typedef struct {
    int         which;
    logic [7:0] data;
    logic       ferr;
    int         cyc;
  } ev_t;

  ev_t  evq[$];
  int   cyc = 0, last_start = 0, checks = 0, errors = 0;
  int   multi_err = 0, long_err = 0;
  logic [2:0] prev_en = 3'b000;
  logic [2:0] en;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    en = {o_enable_3, o_enable_2, o_enable_1};
    if (!$isunknown(en)) begin
      if ($countones(en) > 1) multi_err++;
      if (en != 3'b000 && prev_en != 3'b000) long_err++;
      if (en != 3'b000) begin
        ev_t e;
        e.which = en[0] ? 1 : (en[1] ? 2 : 3);
        e.data  = o_data;
        e.ferr  = o_frame_error;
        e.cyc   = cyc;
        evq.push_back(e);
      end
      prev_en = en;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bit_out(input logic b);
    rx = b;
    idle(BIT_CYC);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b);
    last_start = cyc;
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(d[i]);
`ifdef UART_ALU_LOADER_PARITY_EN
    bit_out(^d);
`endif
    bit_out(stop_b);
    rx = 1'b1;
  endtask

`ifdef UART_ALU_LOADER_PARITY_EN
  task automatic send_frame_par(input logic [7:0] d, input logic par_b);
    last_start = cyc;
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(d[i]);
    bit_out(par_b);
    bit_out(1'b1);
    rx = 1'b1;
  endtask
`endif

  task automatic test_reset;
    reset = 1'b1;
    rx    = 1'b1;
    idle(3);
    checks++; if (o_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", o_data); end
    checks++; if ({o_enable_3, o_enable_2, o_enable_1} !== 3'b000) begin errors++; $display("FAIL reset_en: got %b expected 000", {o_enable_3, o_enable_2, o_enable_1}); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", o_busy); end
    checks++; if (o_frame_error !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b expected 0", o_frame_error); end
    reset = 1'b0;
    idle(10);
  endtask

  task automatic test_basic;
    logic [7:0] exp_d [3];
    int s0;
    exp_d = '{8'h05, 8'h03, 8'h20};
    evq.delete();
    send_frame(exp_d[0], 1'b1);
    s0 = last_start;
    send_frame(exp_d[1], 1'b1);
    send_frame(exp_d[2], 1'b1);
    idle(20);
    checks++; if (evq.size() !== 3) begin errors++; $display("FAIL basic_count: got %0d enables expected 3", evq.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (evq.size() <= i) begin
        errors++; $display("FAIL basic_ev%0d: got no enable expected en%0d", i, i + 1);
      end else if (evq[i].which !== i + 1 || evq[i].data !== exp_d[i] || evq[i].ferr !== 1'b0) begin
        errors++; $display("FAIL basic_ev%0d: got en%0d data %h ferr %b expected en%0d data %h ferr 0",
                           i, evq[i].which, evq[i].data, evq[i].ferr, i + 1, exp_d[i]);
      end
    end
    checks++;
    if (evq.size() == 0 || evq[0].cyc - s0 !== STOP_LAT) begin
      errors++; $display("FAIL basic_latency: got %0d expected %0d", (evq.size() == 0) ? -1 : evq[0].cyc - s0, STOP_LAT);
    end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL basic_busy: got %b expected 0", o_busy); end
    checks++; if (multi_err !== 0 || long_err !== 0) begin errors++; $display("FAIL basic_pulse: got multi %0d long %0d expected 0 0", multi_err, long_err); end
  endtask

  task automatic test_glitch;
    evq.delete();
    rx = 1'b0;
    idle(16);
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_hi: got %b expected 1", o_busy); end
    rx = 1'b1;
    idle(200);
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_lo: got %b expected 0", o_busy); end
    checks++; if (evq.size() !== 0 || o_frame_error !== 1'b0) begin errors++; $display("FAIL glitch_out: got %0d enables ferr %b expected 0 enables ferr 0", evq.size(), o_frame_error); end
  endtask

  task automatic test_frame_error;
    evq.delete();
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b0);
    idle(20);
    checks++; if (evq.size() !== 1 || evq[0].which !== 1 || evq[0].data !== 8'h11) begin errors++; $display("FAIL ferr_first: got %0d enables expected one en1 with 11", evq.size()); end
    checks++; if (o_frame_error !== 1'b1) begin errors++; $display("FAIL ferr_set: got %b expected 1", o_frame_error); end
    send_frame(8'h0A, 1'b1);
    idle(20);
    checks++;
    if (evq.size() !== 2 || evq[1].which !== 1 || evq[1].data !== 8'h0A || evq[1].ferr !== 1'b0) begin
      errors++; $display("FAIL ferr_recover: got %0d enables (last en%0d data %h ferr %b) expected en1 data 0a ferr 0",
                         evq.size(), evq[evq.size()-1].which, evq[evq.size()-1].data, evq[evq.size()-1].ferr);
    end
    checks++; if (o_frame_error !== 1'b0) begin errors++; $display("FAIL ferr_clear: got %b expected 0", o_frame_error); end
  endtask

  task automatic test_reset_mid;
    logic [7:0] exp_d [3];
    exp_d = '{8'h01, 8'h02, 8'h00};
    evq.delete();
    bit_out(1'b0);
    bit_out(1'b1);
    bit_out(1'b0);
    bit_out(1'b1);
    rx = 1'b0;
    idle(32);
    reset = 1'b1;
    idle(1);
    checks++;
    if (o_data !== 8'h00 || o_busy !== 1'b0 || o_frame_error !== 1'b0 || {o_enable_3, o_enable_2, o_enable_1} !== 3'b000) begin
      errors++; $display("FAIL midreset_out: got data %h busy %b ferr %b en %b expected all 0",
                         o_data, o_busy, o_frame_error, {o_enable_3, o_enable_2, o_enable_1});
    end
    reset = 1'b0;
    rx    = 1'b1;
    idle(700);
    checks++; if (evq.size() !== 0) begin errors++; $display("FAIL midreset_partial: got %0d enables expected 0", evq.size()); end
    for (int i = 0; i < 3; i++) send_frame(exp_d[i], 1'b1);
    idle(20);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (evq.size() <= i || evq[i].which !== i + 1 || evq[i].data !== exp_d[i]) begin
        errors++; $display("FAIL midreset_ev%0d: got %0d enables expected en%0d data %h", i, evq.size(), i + 1, exp_d[i]);
      end
    end
    evq.delete();
    fork
      send_frame(8'h3C, 1'b1);
      begin
        idle(STOP_LAT - 1);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
      end
    join
    idle(20);
    checks++; if (evq.size() !== 0) begin errors++; $display("FAIL reset_dominates: got %0d enables expected 0", evq.size()); end
  endtask

  task automatic test_break;
    evq.delete();
    rx = 1'b0;
    idle(700);
    checks++; if (o_frame_error !== 1'b1) begin errors++; $display("FAIL break_ferr: got %b expected 1", o_frame_error); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL break_hold: got busy %b expected 0", o_busy); end
    idle(300);
    checks++; if (o_busy !== 1'b0 || evq.size() !== 0) begin errors++; $display("FAIL break_idle: got busy %b enables %0d expected 0 0", o_busy, evq.size()); end
    rx = 1'b1;
    idle(20);
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp_d [3];
    exp_d = '{8'hFF, 8'h00, 8'h26};
    evq.delete();
    for (int i = 0; i < 3; i++) send_frame(exp_d[i], 1'b1);
    idle(20);
    checks++; if (evq.size() !== 3) begin errors++; $display("FAIL b2b_count: got %0d enables expected 3", evq.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (evq.size() <= i || evq[i].which !== i + 1 || evq[i].data !== exp_d[i] || evq[i].ferr !== 1'b0) begin
        errors++; $display("FAIL b2b_ev%0d: got %0d enables expected en%0d data %h ferr 0", i, evq.size(), i + 1, exp_d[i]);
      end
    end
    checks++; if (multi_err !== 0 || long_err !== 0) begin errors++; $display("FAIL b2b_pulse: got multi %0d long %0d expected 0 0", multi_err, long_err); end
  endtask

`ifdef UART_ALU_LOADER_PARITY_EN
  task automatic test_parity;
    evq.delete();
    send_frame_par(8'h07, 1'b0);
    idle(20);
    checks++; if (evq.size() !== 0 || o_frame_error !== 1'b1) begin errors++; $display("FAIL parity_bad: got %0d enables ferr %b expected 0 enables ferr 1", evq.size(), o_frame_error); end
    send_frame_par(8'h07, 1'b1);
    idle(20);
    checks++;
    if (evq.size() !== 1 || evq[0].which !== 1 || evq[0].data !== 8'h07 || o_frame_error !== 1'b0) begin
      errors++; $display("FAIL parity_good: got %0d enables ferr %b expected en1 data 07 ferr 0", evq.size(), o_frame_error);
    end
  endtask
`endif

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    rx    = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_glitch();
    test_frame_error();
    test_reset_mid();
    test_break();
    test_back_to_back();
`ifdef UART_ALU_LOADER_PARITY_EN
    test_parity();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_alu_loader.md
UART_ALU_LOADER -- requirements
Module: uart_alu_loader

Interface
REQ-001 Parameter NB_DATA, default 8: width of received payload and of o_data.
REQ-002 Parameter CLK_FREQ, default 50000000: i_clk frequency in Hz.
REQ-003 Parameter BAUD_RATE, default 19200: serial line bit rate.
REQ-004 Port i_clk  input  1  single system clock; all logic on rising edge.
REQ-005 Port i_reset  input  1  synchronous, active-high reset.
REQ-006 Port i_rx  input  1  asynchronous UART serial line, idle high.
REQ-007 Port o_data  output  NB_DATA  last accepted byte, fed to ALU i_data.
REQ-008 Port o_enable_1  output  1  one-cycle pulse: o_data is operand A.
REQ-009 Port o_enable_2  output  1  one-cycle pulse: o_data is operand B.
REQ-010 Port o_enable_3  output  1  one-cycle pulse: o_data is opcode.
REQ-011 Port o_busy  output  1  high while a serial frame is being received.
REQ-012 Port o_frame_error  output  1  sticky error flag, drives an LED.

Function
REQ-013 i_rx SHALL pass through a 2-flop synchronizer; all logic uses the synchronized value.
REQ-014 Tick generator SHALL emit a one-cycle tick every DIV = floor(CLK_FREQ/(BAUD_RATE*16)) cycles (16x oversampling); counter wraps DIV-1 -> 0.
REQ-015 RX FSM states SHALL be IDLE, START, DATA, STOP (PARITY added per REQ-031).
REQ-016 IDLE -> START on synchronized line low; tick counter restarted at 0.
REQ-017 START: after 8 ticks sample line; low -> DATA, high -> IDLE (glitch, no byte, no error).
REQ-018 DATA: sample every 16 ticks, NB_DATA bits, LSB first, into shift register.
REQ-019 STOP: sample after 16 ticks; high -> byte valid, low -> frame error; either -> IDLE.
REQ-020 o_busy SHALL be high in every RX state except IDLE.
REQ-021 Loader FSM states SHALL be WAIT_A -> WAIT_B -> WAIT_OP -> WAIT_A, advancing one step per valid byte.
REQ-022 On valid byte: o_data loaded and the enable matching current loader state asserted in the same cycle, exactly one cycle after the stop-bit sample cycle.
REQ-023 At most one of o_enable_1/2/3 SHALL be high in any cycle; o_data SHALL hold its value between valid bytes.
REQ-024 On frame error: byte discarded, no enable pulse, o_frame_error set, loader returns to WAIT_A.
REQ-025 o_frame_error SHALL clear on the next valid byte (same cycle as its enable pulse).
REQ-026 Back-to-back frames (start bit immediately after stop bit) SHALL all be received.
REQ-027 Line low in IDLE for the entire frame (break) SHALL yield a frame error, then stay IDLE until line returns high.

Reset
REQ-028 i_reset SHALL set: o_data=0, all enables=0, o_busy=0, o_frame_error=0, RX FSM=IDLE, loader=WAIT_A, tick and bit counters=0, synchronizer flops=1.
REQ-029 Reset mid-frame SHALL abort it; partial byte discarded, no enable issued.
REQ-030 Reset SHALL dominate any simultaneous byte completion.

Configuration
REQ-031 Macro UART_ALU_LOADER_PARITY_EN defined: PARITY state between DATA and STOP samples one even-parity bit; mismatch treated as frame error (REQ-024) regardless of stop bit.
REQ-032 Macro undefined: frame is 8N1, no PARITY state, no parity logic.

Verification (CLK_FREQ=50000000, BAUD_RATE=19200, DIV=162)
REQ-033 Send 0x05, 0x03, 0x20 -> en1 with o_data=0x05, en2 with 0x03, en3 with 0x20, each exactly 1 cycle; o_frame_error=0; o_busy=0 after last stop bit.
REQ-034 Pulse i_rx low for 4 ticks only -> no enable, o_frame_error=0, o_busy returns 0, FSM IDLE.
REQ-035 Send 0x11 OK, then 0x22 with stop bit=0 -> no en2, o_frame_error=1; then 0x0A -> en1 with o_data=0x0A, o_frame_error=0.
REQ-036 Assert i_reset during bit 3 of 0x55 -> all outputs 0 next cycle; then 0x01,0x02,0x00 -> en1/en2/en3 in order.
REQ-037 With UART_ALU_LOADER_PARITY_EN: 0x07 with parity bit 0 -> frame error, no enable; 0x07 with parity 1 -> en1, o_data=0x07.
REQ-038 Send 0xFF,0x00,0x26 with zero idle gap -> all three enables in order, no error.
